regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, two-read core register file.
- Adds configurable read/write port counts, 1-cycle registered reads with write-first bypass, and write-port collision priority.
- Adds an optional hardwired zero register and a post-reset clear sequencer, so the array maps to memory without a one-cycle reset.
- Sits between decode (read addresses) and writeback (one write port per retiring lane) in the core datapath.

Parameters:
DATA_WIDTH, 32, width of each register
NUM_REGS, 32, number of registers, >=2; AW = $clog2(NUM_REGS) (localparam)
NUM_RD, 2, number of read ports, >=1
NUM_WR, 1, number of write ports, >=1
ZERO_REG, 1, 1: register 0 reads as 0 and ignores writes; 0: register 0 is an ordinary register
DEBUG_REG, 31, default register index driven on debug_data after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
rd_en  in  NUM_RD  per-port read request
rd_addr  in  NUM_RD*AW  read addresses; port p uses bits [p*AW +: AW]
rd_data  out  NUM_RD*DATA_WIDTH  read data, valid one cycle after request
rd_valid  out  NUM_RD  per-port read data valid
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*DATA_WIDTH  write data
ready  out  1  high once the clear sequence is done; reads and writes are accepted only while high
debug_sel_en  in  1  load debug_sel into the debug select register
debug_sel  in  AW  debug register index
debug_data  out  DATA_WIDTH  contents of the selected register (array state, no bypass)

Behaviour:
- Reset (rst==0 at a clk edge):
  - state<=INIT, clear counter<=0, ready<=0.
  - rd_data<=0, rd_valid<=0, debug select<=DEBUG_REG.
  - Array contents are not reset directly.
- State machine, INIT -> RUN:
  - INIT: each cycle writes 0 to entry [counter], then counter+1.
  - After the write of entry NUM_REGS-1, state<=RUN and ready<=1 on that same edge.
  - INIT takes exactly NUM_REGS cycles; ready is first seen high on cycle NUM_REGS after reset release.
  - In INIT, wr_en and rd_en are ignored; rd_valid stays 0.
  - RUN stays in RUN until the next reset. Reset asserted mid-INIT or mid-RUN restarts INIT at counter 0 and drops any in-flight read (rd_valid<=0).
- Writes (RUN):
  - For each port w with wr_en[w], RF[wr_addr[w]] <= wr_data[w] at the clk edge.
  - Same-address collision: the highest-index enabled port wins; others are dropped.
  - ZERO_REG=1: writes to address 0 are discarded.
  - Addresses >= NUM_REGS (non-power-of-2 depth) are discarded.
- Reads (RUN):
  - rd_valid[p] <= rd_en[p]. When rd_en[p]==1, rd_data[p] <= effective value of rd_addr[p].
  - When rd_en[p]==0, rd_data[p] holds its previous value and rd_valid[p]<=0.
- Effective read value, in priority order:
  - 0 if ZERO_REG=1 and addr==0.
  - 0 if addr >= NUM_REGS.
  - Else wr_data of the winning same-cycle write to that address (write-first bypass).
  - Else the array contents.
- Read latency: 1 cycle. Any number of read ports may read the same address in a cycle.
- Debug:
  - debug_sel_en==1 loads the debug select register (also allowed in INIT).
  - debug_data is combinational from the array at the selected index. It shows post-edge state, has no bypass, and reads 0 for reg 0 when ZERO_REG=1.
- Widths: no arithmetic on data; the counter is AW+1 bits so NUM_REGS == 2^AW terminates cleanly.

Test Plan:
- Reset clear: release rst, hold wr_en=1 with addr 5, data 0xDEADBEEF, throughout INIT -> ready rises on cycle 32; read of reg 5 returns 0 with rd_valid=1 the next cycle; every register reads 0.
- Basic write/read: write reg 7=0x12345678; read reg 7 on both ports the next cycle -> both rd_data=0x12345678 after 1 cycle, rd_valid=2'b11.
- Bypass and zero: same cycle, wr reg 9=0xA5A5A5A5 while port 0 reads reg 9 and port 1 reads reg 0 -> port 0 gets 0xA5A5A5A5, port 1 gets 0. A write of 0xFFFFFFFF to reg 0 leaves reg 0 reading 0.
- Collision (NUM_WR=2): port 0 writes reg 3=0x11, port 1 writes reg 3=0x22 -> reg 3 reads 0x22; a bypassed read in the same cycle also returns 0x22.
- Hold and debug: rd_en=0 after a read of 0x12345678 -> rd_data stays 0x12345678, rd_valid=0. Write reg 31=0xCAFE0001 -> debug_data=0xCAFE0001 after the edge; debug_sel_en with debug_sel=7 switches debug_data to reg 7.
- Reset mid-op: assert rst during RUN with a read in flight -> rd_valid=0, ready=0; after release, all registers are 0 again after 32 cycles.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read/write ports, ready, and debug view.
// The decode/writeback side uses the master modport, the register file uses slave.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD*AW-1:0]         rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_valid;
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*AW-1:0]         wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic                         ready;
  logic                         debug_sel_en;
  logic [AW-1:0]                debug_sel;
  logic [DATA_WIDTH-1:0]        debug_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, debug_sel_en, debug_sel,
    input  rd_data, rd_valid, ready, debug_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, debug_sel_en, debug_sel,
    output rd_data, rd_valid, ready, debug_data
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered write-first reads, optional
// hardwired zero register, and a post-reset clear sequence instead of an array reset.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1,
  parameter int DEBUG_REG  = 31
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic {INIT, RUN} state_t;

  state_t                       state;
  logic [AW:0]                  clr_cnt;
  logic                         ready_q;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_RD-1:0]            rd_valid_q;
  logic [AW-1:0]                dbg_sel_q;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  logic [AW-1:0]         wa     [NUM_WR];
  logic [DATA_WIDTH-1:0] wd     [NUM_WR];
  logic [NUM_WR-1:0]     wr_ok;
  logic [AW-1:0]         ra     [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_eff [NUM_RD];

  // An address is live if it maps to a real, writable entry (not the zero register).
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wa[w]    = bus.wr_addr[w*AW +: AW];
    assign wd[w]    = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
    assign wr_ok[w] = bus.wr_en[w] && addr_live(wa[w]);
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign ra[p] = bus.rd_addr[p*AW +: AW];
  end

  // Ascending port scan, so the highest-index matching writer is the one bypassed.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_eff[p] = '0;
      if (addr_live(ra[p])) begin
        rd_eff[p] = mem[ra[p]];
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_ok[w] && (wa[w] == ra[p])) rd_eff[p] = wd[w];
        end
      end
    end
  end

  // No reset on the array so it can map onto RAM; the INIT sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (rst && (state == INIT)) begin
      mem[clr_cnt[AW-1:0]] <= '0;
    end else if (rst && (state == RUN)) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) mem[wa[w]] <= wd[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= INIT;
      clr_cnt    <= '0;
      ready_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      dbg_sel_q  <= AW'(DEBUG_REG);
    end else begin
      if (bus.debug_sel_en) dbg_sel_q <= bus.debug_sel;
      case (state)
        INIT: begin
          rd_valid_q <= '0;
          clr_cnt    <= clr_cnt + 1'b1;
          if (clr_cnt == (AW+1)'(NUM_REGS - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          for (int p = 0; p < NUM_RD; p++) begin
            rd_valid_q[p] <= bus.rd_en[p];
            if (bus.rd_en[p]) rd_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_eff[p];
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.ready      = ready_q;
  assign bus.debug_data = addr_live(dbg_sel_q) ? mem[dbg_sel_q] : '0;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read, 2 write ports): clear sequence, bypass,
// zero register, write collision, read hold, debug view and mid-run reset.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .DEBUG_REG(31)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]    wr_en;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [1:0]    rd_en;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          dsel_en;
    logic [AW-1:0] dsel;
    logic [1:0]    exp_valid;
    logic [DW-1:0] exp_d0;
    logic [DW-1:0] exp_d1;
    logic [DW-1:0] exp_dbg;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    check_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic set_idle();
    bus.wr_en        = '0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.rd_en        = '0;
    bus.rd_addr      = '0;
    bus.debug_sel_en = 1'b0;
    bus.debug_sel    = '0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.wr_en        = v.wr_en;
    bus.wr_addr      = {v.wa1, v.wa0};
    bus.wr_data      = {v.wd1, v.wd0};
    bus.rd_en        = v.rd_en;
    bus.rd_addr      = {v.ra1, v.ra0};
    bus.debug_sel_en = v.dsel_en;
    bus.debug_sel    = v.dsel;
  endtask

  // Counts cycles after reset release until ready; a missing ready shows up as 0.
  task automatic wait_ready(input string tag);
    int   cyc;
    logic seen_valid;
    cyc = 0;
    seen_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.rd_valid != 2'b00) seen_valid = 1'b1;
      if (bus.ready) begin
        cyc = i;
        break;
      end
    end
    check_output({tag, "_init_cycles"}, DW'(cyc), 32'd32);
    check_output({tag, "_init_rd_valid"}, {31'b0, seen_valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < NR / 2; r++) begin
      bus.rd_en   = 2'b11;
      bus.rd_addr = {AW'(r + NR / 2), AW'(r)};
      tick();
      check_output($sformatf("%s_zero_r%0d", tag, r), bus.rd_data[DW-1:0], 32'd0);
      check_output($sformatf("%s_zero_r%0d", tag, r + NR / 2), bus.rd_data[2*DW-1:DW], 32'd0);
    end
    bus.rd_en = 2'b00;
  endtask

  initial begin
    //            wr_en  wa0    wd0            wa1    wd1            rd_en  ra0    ra1    dse   dsel   ev     d0             d1             dbg
    vecs[0]  = '{2'b01, 5'd7,  32'h12345678, 5'd0,  32'h0,         2'b00, 5'd0,  5'd0,  1'b0, 5'd0,  2'b00, 32'h0,         32'h0,         32'h0};
    vecs[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  2'b11, 32'h12345678, 32'h12345678, 32'h0};
    vecs[2]  = '{2'b01, 5'd9,  32'hA5A5A5A5, 5'd0,  32'h0,         2'b11, 5'd9,  5'd0,  1'b0, 5'd0,  2'b11, 32'hA5A5A5A5, 32'h0,         32'h0};
    vecs[3]  = '{2'b10, 5'd0,  32'h0,        5'd0,  32'hFFFFFFFF,  2'b11, 5'd0,  5'd9,  1'b0, 5'd0,  2'b11, 32'h0,         32'hA5A5A5A5, 32'h0};
    vecs[4]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         2'b11, 5'd0,  5'd7,  1'b0, 5'd0,  2'b11, 32'h0,         32'h12345678, 32'h0};
    vecs[5]  = '{2'b11, 5'd3,  32'h11,       5'd3,  32'h22,        2'b11, 5'd3,  5'd7,  1'b0, 5'd0,  2'b11, 32'h22,        32'h12345678, 32'h0};
    vecs[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         2'b11, 5'd3,  5'd7,  1'b0, 5'd0,  2'b11, 32'h22,        32'h12345678, 32'h0};
    vecs[7]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         2'b00, 5'd1,  5'd2,  1'b0, 5'd0,  2'b00, 32'h22,        32'h12345678, 32'h0};
    vecs[8]  = '{2'b10, 5'd0,  32'h0,        5'd31, 32'hCAFE0001,  2'b11, 5'd31, 5'd9,  1'b0, 5'd0,  2'b11, 32'hCAFE0001, 32'hA5A5A5A5, 32'hCAFE0001};
    vecs[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,         2'b00, 5'd0,  5'd0,  1'b1, 5'd7,  2'b00, 32'hCAFE0001, 32'hA5A5A5A5, 32'h12345678};
    vecs[10] = '{2'b11, 5'd7,  32'h77,       5'd12, 32'hBB,        2'b11, 5'd12, 5'd7,  1'b0, 5'd0,  2'b11, 32'hBB,        32'h77,        32'h77};
    vecs[11] = '{2'b01, 5'd12, 32'h1,        5'd0,  32'h0,         2'b11, 5'd12, 5'd12, 1'b0, 5'd0,  2'b11, 32'h1,         32'h1,         32'h77};

    set_idle();
    rst = 1'b0;
    repeat (3) tick();
    check_output("reset_ready", {31'b0, bus.ready}, 32'd0);
    check_output("reset_rd_valid", {30'b0, bus.rd_valid}, 32'd0);
    check_output("reset_rd_data0", bus.rd_data[DW-1:0], 32'd0);
    check_output("reset_rd_data1", bus.rd_data[2*DW-1:DW], 32'd0);

    // Writes and reads held during INIT must be ignored.
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd5};
    bus.wr_data = {32'h0, 32'hDEADBEEF};
    bus.rd_en   = 2'b11;
    bus.rd_addr = {5'd5, 5'd5};
    rst = 1'b1;
    wait_ready("first");
    set_idle();

    bus.rd_en   = 2'b11;
    bus.rd_addr = {5'd0, 5'd5};
    tick();
    check_output("clear_rd_valid", {30'b0, bus.rd_valid}, 32'd3);
    check_output("clear_reg5", bus.rd_data[DW-1:0], 32'd0);
    check_all_zero("first");
    check_output("clear_debug31", bus.debug_data, 32'd0);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i]);
      tick();
      check_output($sformatf("vec%0d_valid", i), {30'b0, bus.rd_valid}, {30'b0, vecs[i].exp_valid});
      check_output($sformatf("vec%0d_data0", i), bus.rd_data[DW-1:0], vecs[i].exp_d0);
      check_output($sformatf("vec%0d_data1", i), bus.rd_data[2*DW-1:DW], vecs[i].exp_d1);
      check_output($sformatf("vec%0d_debug", i), bus.debug_data, vecs[i].exp_dbg);
    end
    set_idle();

    // Reset with a read in flight; array survives reset until the INIT sweep runs.
    bus.rd_en   = 2'b11;
    bus.rd_addr = {5'd7, 5'd7};
    tick();
    check_output("pre_rst_valid", {30'b0, bus.rd_valid}, 32'd3);
    check_output("pre_rst_data0", bus.rd_data[DW-1:0], 32'h77);
    rst = 1'b0;
    tick();
    check_output("mid_rst_valid", {30'b0, bus.rd_valid}, 32'd0);
    check_output("mid_rst_ready", {31'b0, bus.ready}, 32'd0);
    check_output("mid_rst_data0", bus.rd_data[DW-1:0], 32'd0);
    check_output("mid_rst_debug_sel", bus.debug_data, 32'hCAFE0001);
    set_idle();
    rst = 1'b1;
    wait_ready("second");
    check_all_zero("second");
    check_output("second_debug31", bus.debug_data, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
